line_buffer_5rows: RTL and testbench

- Producer-side front end for the 5x5 window buffer.
- Accepts a raster-order 8-bit pixel stream, one pixel per cycle, qualified by done_i.
- Holds the previous four image rows in circular line memories.
- For every accepted pixel, emits five vertically aligned pixels of the same column (rows r-4..r) on S1_o..S5_o. These drive the window buffer's S1_i..S5_i directly.
- Sits between the pixel source and the window buffer.

---
 rtl/line_buffer_5rows.sv | 85 ++++++++
 tb/tb_line_buffer_5rows.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/line_buffer_5rows.sv
// line_buffer_5rows: keeps the last four image rows in per-column line memories and
// emits five vertically aligned pixels per accepted raster-order input pixel.
module line_buffer_5rows #(
    parameter int COLS = 7,
    parameter int ROWS = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       done_i,
    input  logic [7:0] data_i,
    output logic [7:0] S1_o,
    output logic [7:0] S2_o,
    output logic [7:0] S3_o,
    output logic [7:0] S4_o,
    output logic [7:0] S5_o,
    output logic       done_o,
    output logic       progress_done_o
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [RW-1:0] ROW_FIRST_OUT = RW'(4);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [7:0] l0_q [COLS];
    logic [7:0] l1_q [COLS];
    logic [7:0] l2_q [COLS];
    logic [7:0] l3_q [COLS];
    logic [7:0] s1_q, s2_q, s3_q, s4_q, s5_q;
    logic done_q, prog_q;
    logic col_last, row_last;

    always_comb begin
        col_last = col_q == COL_LAST;
        row_last = row_q == ROW_LAST;
        col_d = !done_i ? col_q : col_last ? '0 : col_q + 1'b1;
        row_d = !(done_i && col_last) ? row_q : row_last ? '0 : row_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
            s4_q   <= '0;
            s5_q   <= '0;
            done_q <= 1'b0;
            prog_q <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            done_q <= done_i && row_q >= ROW_FIRST_OUT;
            prog_q <= done_i && row_last && col_last;
            if (done_i) begin
                s5_q <= data_i;
                s4_q <= l0_q[col_q];
                s3_q <= l1_q[col_q];
                s2_q <= l2_q[col_q];
                s1_q <= l3_q[col_q];
            end
        end
    end

    // Line memories need no reset: rows 0..3 of a new frame overwrite them before use.
    always_ff @(posedge clk) begin
        if (done_i && !rst) begin
            l0_q[col_q] <= data_i;
            l1_q[col_q] <= l0_q[col_q];
            l2_q[col_q] <= l1_q[col_q];
            l3_q[col_q] <= l2_q[col_q];
        end
    end

    assign S1_o = s1_q;
    assign S2_o = s2_q;
    assign S3_o = s3_q;
    assign S4_o = s4_q;
    assign S5_o = s5_q;
    assign done_o = done_q;
    assign progress_done_o = prog_q;
endmodule

// File: tb/tb_line_buffer_5rows.sv
// tb_line_buffer_5rows: drives a 7x7 and a 5x5 instance with one shared pixel stream and
// compares both against a frame-image reference model.
module tb_line_buffer_5rows;
    logic clk = 1'b0;
    logic rst, done_i;
    logic [7:0] data_i;
    logic [7:0] a1, a2, a3, a4, a5, b1, b2, b3, b4, b5;
    logic a_done, a_prog, b_done, b_prog;

    int err = 0;
    int n = 0;
    int pulses = 0;
    int progs = 0;

    int cols [2] = '{7, 5};
    int rows [2] = '{7, 5};
    int img [2][7][7];
    int pos [2];
    int es [2][5];
    bit kn [2][5];
    bit ed [2];
    bit ep [2];

    always #5 clk = ~clk;

    line_buffer_5rows #(.COLS(7), .ROWS(7)) dut7 (
        .clk(clk), .rst(rst), .done_i(done_i), .data_i(data_i),
        .S1_o(a1), .S2_o(a2), .S3_o(a3), .S4_o(a4), .S5_o(a5),
        .done_o(a_done), .progress_done_o(a_prog)
    );

    line_buffer_5rows #(.COLS(5), .ROWS(5)) dut5 (
        .clk(clk), .rst(rst), .done_i(done_i), .data_i(data_i),
        .S1_o(b1), .S2_o(b2), .S3_o(b3), .S4_o(b4), .S5_o(b5),
        .done_o(b_done), .progress_done_o(b_prog)
    );

    task automatic check(input string tag, input int got, input int exp);
        n++;
        if (got !== exp) begin
            err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Frame-position model: output lanes are the pixels of this column in rows r-4..r.
    task automatic model(input int k, input bit r, input bit v, input int d);
        int row, col, rr;
        if (r) begin
            pos[k] = 0;
            ed[k] = 0;
            ep[k] = 0;
            for (int i = 0; i < 5; i++) begin
                es[k][i] = 0;
                kn[k][i] = 1;
            end
        end else begin
            ed[k] = 0;
            ep[k] = 0;
            if (v) begin
                row = pos[k] / cols[k];
                col = pos[k] % cols[k];
                img[k][row][col] = d;
                for (int i = 0; i < 5; i++) begin
                    rr = row - 4 + i;
                    kn[k][i] = rr >= 0;
                    if (rr >= 0) es[k][i] = img[k][rr][col];
                end
                ed[k] = row >= 4;
                ep[k] = pos[k] == rows[k] * cols[k] - 1;
                pos[k] = (pos[k] + 1) % (rows[k] * cols[k]);
            end
        end
    endtask

    task automatic step(input bit v, input int d, input bit r);
        int g [2][5];
        rst = r;
        done_i = v;
        data_i = 8'(d);
        @(posedge clk);
        model(0, r, v, d);
        model(1, r, v, d);
        @(negedge clk);
        g[0] = '{int'(a1), int'(a2), int'(a3), int'(a4), int'(a5)};
        g[1] = '{int'(b1), int'(b2), int'(b3), int'(b4), int'(b5)};
        pulses += int'(a_done);
        progs += int'(a_prog);
        check("done7", int'(a_done), int'(ed[0]));
        check("prog7", int'(a_prog), int'(ep[0]));
        check("done5", int'(b_done), int'(ed[1]));
        check("prog5", int'(b_prog), int'(ep[1]));
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 5; i++)
                if (kn[k][i]) check($sformatf("S%0d_c%0d", i + 1, cols[k]), g[k][i], es[k][i]);
    endtask

    initial begin
        rst = 1'b1;
        done_i = 1'b0;
        data_i = 8'd0;
        step(0, 0, 1);
        step(0, 0, 1);
        check("rst_S1", int'(a1), 0);
        check("rst_done", int'(a_done), 0);
        pulses = 0;
        progs = 0;
        for (int i = 0; i < 49; i++) begin
            step(1, i + 1, 0);
            if (i == 27) check("no_early_done", pulses, 0);
            if (i == 28) begin
                check("first_S1", int'(a1), 1);
                check("first_S3", int'(a3), 15);
                check("first_S5", int'(a5), 29);
            end
        end
        check("last_S1", int'(a1), 21);
        check("last_S5", int'(a5), 49);
        check("last_prog", int'(a_prog), 1);
        check("pulses_f1", pulses, 21);
        check("progs_f1", progs, 1);
        for (int i = 0; i < 49; i++) begin
            step(1, i + 101, 0);
            if (i == 27) check("no_f2_early", pulses, 21);
            if (i == 28) check("f2_first_S1", int'(a1), 101);
        end
        step(0, 0, 0);
        check("idle_done", int'(a_done), 0);
        check("pulses_f2", pulses, 42);
        check("progs_f2", progs, 2);
        for (int i = 0; i < 33; i++) step(1, i + 1, 0);
        step(1, 34, 1);
        check("midrst_S5", int'(a5), 0);
        for (int i = 0; i < 49; i++) begin
            step(1, i + 1, 0);
            if (i == 28) check("rst_first_S1", int'(a1), 1);
            if (i == 30) begin
                for (int j = 0; j < 3; j++) step(0, 255, 0);
                check("hold_S5", int'(a5), 31);
                check("hold_done", int'(a_done), 0);
            end
        end
        for (int t = 0; t < 1500; t++)
            step($urandom_range(3) != 0, int'($urandom_range(255)), $urandom_range(199) == 0);
        step(0, 0, 0);
        $display("Result: errors=%0d of %0d checks", err, n);
        $finish;
    end
endmodule
